// File: rtl/cook_sequencer.sv
// Microwave front-panel sequencer: button pulses and door level in, cook/defrost
// countdown in whole seconds, motor-controller levels and end-of-cycle beep out.
module cook_sequencer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int DEFROST_SEC = 300,
    parameter int BEEP_SEC    = 3,
    parameter int MAX_SEC     = 5999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_cancel,
    input  logic        btn_defrost,
    input  logic        btn_add_min,
    input  logic        btn_add_10s,
    input  logic        door_open,
    output logic        start,
    output logic        defrost_start,
    output logic [12:0] remain_sec,
    output logic        busy,
    output logic        beep,
    output logic [2:0]  state
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int BEEP_W = $clog2(BEEP_SEC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET     = 3'd1,
        COOK    = 3'd2,
        DEFROST = 3'd3,
        PAUSE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              cur_state, nxt_state;
    logic [12:0]         remain, remain_n;
    logic [TICK_W-1:0]   tick_cnt, tick_n;
    logic [BEEP_W-1:0]   beep_cnt, beep_n;
    logic                mode_defrost, mode_n;
    logic                door_q;
    logic [6:0]          add_amt;
    logic                any_btn;
    logic                wrap;
    logic [12:0]         dec_val;
    logic [12:0]         ext_val;

    function automatic logic [12:0] sat_add(input logic [12:0] base, input logic [6:0] amt);
        logic [13:0] sum;
        sum = {1'b0, base} + {7'd0, amt};
        if (sum > 14'(MAX_SEC))
            return 13'(MAX_SEC);
        return sum[12:0];
    endfunction

    always_comb begin
        add_amt = (btn_add_min ? 7'd60 : 7'd0) + (btn_add_10s ? 7'd10 : 7'd0);
        any_btn = btn_start | btn_cancel | btn_defrost | btn_add_min | btn_add_10s;
        wrap    = (tick_cnt == TICK_W'(TICK_DIV - 1));
        dec_val = wrap ? remain - 13'd1 : remain;
        ext_val = sat_add(dec_val, add_amt);

        nxt_state = cur_state;
        remain_n  = remain;
        tick_n    = tick_cnt;
        beep_n    = beep_cnt;
        mode_n    = mode_defrost;

        case (cur_state)
            IDLE: begin
                if (btn_cancel) begin
                    remain_n = 13'd0;
                end else if (btn_defrost && !door_open) begin
                    nxt_state = DEFROST;
                    remain_n  = 13'(DEFROST_SEC);
                    tick_n    = '0;
                end else if (add_amt != 7'd0) begin
                    nxt_state = SET;
                    remain_n  = sat_add(remain, add_amt);
                end
            end
            SET: begin
                if (btn_cancel) begin
                    nxt_state = IDLE;
                    remain_n  = 13'd0;
                end else if (btn_start && !door_open && remain != 13'd0) begin
                    nxt_state = COOK;
                    tick_n    = '0;
                end else if (add_amt != 7'd0) begin
                    remain_n = sat_add(remain, add_amt);
                end
            end
            COOK, DEFROST: begin
                tick_n = wrap ? '0 : tick_cnt + 1'b1;
                if (btn_cancel) begin
                    nxt_state = IDLE;
                    remain_n  = 13'd0;
                    tick_n    = '0;
                end else if (door_open) begin
                    // The tick that lands on this edge still counts.
                    nxt_state = PAUSE;
                    mode_n    = (cur_state == DEFROST);
                    remain_n  = dec_val;
                    tick_n    = '0;
                end else if (ext_val == 13'd0) begin
                    nxt_state = DONE;
                    remain_n  = 13'd0;
                    tick_n    = '0;
                    beep_n    = '0;
                end else begin
                    remain_n = ext_val;
                end
            end
            PAUSE: begin
                if (btn_cancel) begin
                    nxt_state = IDLE;
                    remain_n  = 13'd0;
                end else if (btn_start && !door_open) begin
                    nxt_state = mode_defrost ? DEFROST : COOK;
                    tick_n    = '0;
                end
            end
            DONE: begin
                tick_n = wrap ? '0 : tick_cnt + 1'b1;
                if (any_btn || (door_open && !door_q)) begin
                    nxt_state = IDLE;
                    remain_n  = 13'd0;
                    tick_n    = '0;
                    beep_n    = '0;
                end else if (wrap) begin
                    if (beep_cnt == BEEP_W'(BEEP_SEC - 1)) begin
                        nxt_state = IDLE;
                        beep_n    = '0;
                    end else begin
                        beep_n = beep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                remain_n  = 13'd0;
                tick_n    = '0;
                beep_n    = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= IDLE;
            remain        <= 13'd0;
            tick_cnt      <= '0;
            beep_cnt      <= '0;
            mode_defrost  <= 1'b0;
            door_q        <= 1'b0;
            start         <= 1'b0;
            defrost_start <= 1'b0;
            busy          <= 1'b0;
            beep          <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            remain        <= remain_n;
            tick_cnt      <= tick_n;
            beep_cnt      <= beep_n;
            mode_defrost  <= mode_n;
            door_q        <= door_open;
            start         <= (nxt_state == COOK);
            defrost_start <= (nxt_state == DEFROST);
            busy          <= (nxt_state == COOK) || (nxt_state == DEFROST) || (nxt_state == PAUSE);
            beep          <= (nxt_state == DONE);
        end
    end

    assign remain_sec = remain;
    assign state      = cur_state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with TICK_DIV=10, DEFROST_SEC=5, BEEP_SEC=3.
module tb_cook_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start, btn_cancel, btn_defrost, btn_add_min, btn_add_10s;
    logic        door_open;
    logic        start, defrost_start, busy, beep;
    logic [12:0] remain_sec;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    cook_sequencer #(
        .TICK_DIV(10),
        .DEFROST_SEC(5),
        .BEEP_SEC(3),
        .MAX_SEC(5999)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .btn_cancel(btn_cancel),
        .btn_defrost(btn_defrost),
        .btn_add_min(btn_add_min),
        .btn_add_10s(btn_add_10s),
        .door_open(door_open),
        .start(start),
        .defrost_start(defrost_start),
        .remain_sec(remain_sec),
        .busy(busy),
        .beep(beep),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_btns();
        btn_start = 0; btn_cancel = 0; btn_defrost = 0; btn_add_min = 0; btn_add_10s = 0;
    endtask

    task automatic test_reset();
        rst = 1; door_open = 0; clear_btns();
        step(); step();
        n_cmp++;
        if ({state, remain_sec, start, defrost_start, busy, beep} !== 20'd0) begin
            n_bad++; $display("FAIL reset_init: state=%0d remain=%0d outs=%b%b%b%b expected all 0",
                              state, remain_sec, start, defrost_start, busy, beep);
        end
        rst = 0;
        btn_add_10s = 1; step(); clear_btns();
        btn_start = 1; step(); clear_btns();
        repeat (20) step();
        rst = 1; step();
        n_cmp++;
        if ({state, remain_sec, start, defrost_start, busy, beep} !== 20'd0) begin
            n_bad++; $display("FAIL reset_mid_cook: state=%0d remain=%0d outs=%b%b%b%b expected all 0",
                              state, remain_sec, start, defrost_start, busy, beep);
        end
        step(); rst = 0; step();
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++; $display("FAIL reset_release: state=%0d expected 0", state);
        end
    endtask

    task automatic test_basic_cook();
        int cnt;
        btn_start = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd0 || start !== 1'b0) begin
            n_bad++; $display("FAIL idle_start_ignored: state=%0d start=%b expected 0/0", state, start);
        end
        btn_add_10s = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd1 || remain_sec !== 13'd10) begin
            n_bad++; $display("FAIL set_add10: state=%0d remain=%0d expected 1/10", state, remain_sec);
        end
        btn_start = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd2 || start !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL cook_entry: state=%0d start=%b busy=%b expected 2/1/1", state, start, busy);
        end
        cnt = 1;
        step();
        while (start === 1'b1 && cnt < 200) begin
            step(); cnt++;
        end
        n_cmp++;
        if (cnt != 100) begin
            n_bad++; $display("FAIL cook_cycles: got %0d cycles expected 100", cnt);
        end
        n_cmp++;
        if (state !== 3'd5 || beep !== 1'b1 || remain_sec !== 13'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL cook_done: state=%0d beep=%b remain=%0d busy=%b expected 5/1/0/0",
                              state, beep, remain_sec, busy);
        end
        cnt = 0;
        while (beep === 1'b1 && cnt < 200) begin
            step(); cnt++;
        end
        n_cmp++;
        if (cnt != 30 || state !== 3'd0) begin
            n_bad++; $display("FAIL beep_cycles: got %0d cycles state=%0d expected 30/0", cnt, state);
        end
    endtask

    task automatic test_defrost();
        int cnt;
        logic saw_start;
        btn_defrost = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd3 || defrost_start !== 1'b1 || remain_sec !== 13'd5) begin
            n_bad++; $display("FAIL defrost_entry: state=%0d dstart=%b remain=%0d expected 3/1/5",
                              state, defrost_start, remain_sec);
        end
        cnt = 0; saw_start = start;
        while (defrost_start === 1'b1 && cnt < 200) begin
            step(); cnt++;
            if (start === 1'b1) saw_start = 1'b1;
            if (cnt == 10) begin
                n_cmp++;
                if (remain_sec !== 13'd4) begin
                    n_bad++; $display("FAIL defrost_first_tick: remain=%0d expected 4", remain_sec);
                end
            end
        end
        n_cmp++;
        if (cnt != 50 || saw_start !== 1'b0 || state !== 3'd5) begin
            n_bad++; $display("FAIL defrost_cycles: got %0d cycles start_seen=%b state=%0d expected 50/0/5",
                              cnt, saw_start, state);
        end
        step();
        door_open = 1; step();
        n_cmp++;
        if (state !== 3'd0 || beep !== 1'b0) begin
            n_bad++; $display("FAIL beep_door_end: state=%0d beep=%b expected 0/0", state, beep);
        end
        door_open = 0; step();
    endtask

    task automatic test_door_pause();
        int cnt;
        btn_add_10s = 1; step(); clear_btns();
        btn_start = 1; step(); clear_btns();
        repeat (30) step();
        door_open = 1; step();
        n_cmp++;
        if (state !== 3'd4 || start !== 1'b0 || remain_sec !== 13'd7 || busy !== 1'b1) begin
            n_bad++; $display("FAIL pause_entry: state=%0d start=%b remain=%0d busy=%b expected 4/0/7/1",
                              state, start, remain_sec, busy);
        end
        btn_start = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd4 || start !== 1'b0 || remain_sec !== 13'd7) begin
            n_bad++; $display("FAIL pause_door_open_start: state=%0d start=%b remain=%0d expected 4/0/7",
                              state, start, remain_sec);
        end
        door_open = 0; step();
        btn_start = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd2 || start !== 1'b1) begin
            n_bad++; $display("FAIL resume: state=%0d start=%b expected 2/1", state, start);
        end
        cnt = 0;
        while (start === 1'b1 && cnt < 200) begin
            step(); cnt++;
        end
        n_cmp++;
        if (cnt != 70 || state !== 3'd5) begin
            n_bad++; $display("FAIL resume_cycles: got %0d cycles state=%0d expected 70/5", cnt, state);
        end
        btn_cancel = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd0 || beep !== 1'b0) begin
            n_bad++; $display("FAIL beep_btn_end: state=%0d beep=%b expected 0/0", state, beep);
        end
    endtask

    task automatic test_tick_coincide();
        btn_add_10s = 1; step(); clear_btns();
        btn_start = 1; step(); clear_btns();
        repeat (9) step();
        btn_add_10s = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd2 || remain_sec !== 13'd19) begin
            n_bad++; $display("FAIL tick_plus_add: state=%0d remain=%0d expected 2/19", state, remain_sec);
        end
        repeat (9) step();
        door_open = 1; step();
        n_cmp++;
        if (state !== 3'd4 || remain_sec !== 13'd18 || start !== 1'b0) begin
            n_bad++; $display("FAIL tick_plus_door: state=%0d remain=%0d start=%b expected 4/18/0",
                              state, remain_sec, start);
        end
        door_open = 0;
        btn_start = 1; step(); clear_btns();
        repeat (9) step();
        btn_cancel = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd0 || remain_sec !== 13'd0 || start !== 1'b0) begin
            n_bad++; $display("FAIL tick_plus_cancel: state=%0d remain=%0d start=%b expected 0/0/0",
                              state, remain_sec, start);
        end
    endtask

    task automatic test_saturation();
        btn_add_min = 1; btn_add_10s = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd1 || remain_sec !== 13'd70) begin
            n_bad++; $display("FAIL dual_add: state=%0d remain=%0d expected 1/70", state, remain_sec);
        end
        btn_add_min = 1;
        repeat (98) step();
        n_cmp++;
        if (remain_sec !== 13'd5950) begin
            n_bad++; $display("FAIL add_98min: remain=%0d expected 5950", remain_sec);
        end
        repeat (3) step();
        clear_btns();
        n_cmp++;
        if (remain_sec !== 13'd5999 || state !== 3'd1) begin
            n_bad++; $display("FAIL add_saturate: remain=%0d state=%0d expected 5999/1", remain_sec, state);
        end
        btn_cancel = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd0 || remain_sec !== 13'd0) begin
            n_bad++; $display("FAIL set_cancel: state=%0d remain=%0d expected 0/0", state, remain_sec);
        end
    endtask

    task automatic test_priority();
        btn_add_10s = 1; step(); clear_btns();
        btn_cancel = 1; door_open = 1; btn_start = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd0 || remain_sec !== 13'd0 || start !== 1'b0) begin
            n_bad++; $display("FAIL prio_cancel: state=%0d remain=%0d start=%b expected 0/0/0",
                              state, remain_sec, start);
        end
        btn_add_10s = 1; step(); clear_btns();
        btn_start = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd1 || start !== 1'b0 || remain_sec !== 13'd10) begin
            n_bad++; $display("FAIL set_start_door_open: state=%0d start=%b remain=%0d expected 1/0/10",
                              state, start, remain_sec);
        end
        door_open = 0;
        btn_defrost = 1; step(); clear_btns();
        n_cmp++;
        if (state !== 3'd1 || defrost_start !== 1'b0) begin
            n_bad++; $display("FAIL set_defrost_ignored: state=%0d dstart=%b expected 1/0", state, defrost_start);
        end
        btn_cancel = 1; step(); clear_btns();
    endtask

    initial begin
        test_reset();
        test_basic_cook();
        test_defrost();
        test_door_pause();
        test_tick_coincide();
        test_saturation();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
